// File: rtl/arch_defs_pkg.sv
// SAP-2 architecture definitions: opcode constants, fetch FSM states and
// the opcode -> instruction length decode used by the fetch unit.
package arch_defs_pkg;

    localparam logic [15:0] RESET_VECTOR_DEF = 16'hF000;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_MOV_AB = 8'h78;
    localparam logic [7:0] OP_HLT    = 8'h76;
    localparam logic [7:0] OP_RET    = 8'hC9;
    localparam logic [7:0] OP_LDI_A  = 8'h3E;
    localparam logic [7:0] OP_ANI    = 8'hE6;
    localparam logic [7:0] OP_ORI    = 8'hF6;
    localparam logic [7:0] OP_XRI    = 8'hEE;
    localparam logic [7:0] OP_IN     = 8'hDB;
    localparam logic [7:0] OP_OUT    = 8'hD3;
    localparam logic [7:0] OP_LDA    = 8'h3A;
    localparam logic [7:0] OP_STA    = 8'h32;
    localparam logic [7:0] OP_JMP    = 8'hC3;
    localparam logic [7:0] OP_CALL   = 8'hCD;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        REQ_OP = 4'd1,
        CAP_OP = 4'd2,
        REQ_B2 = 4'd3,
        CAP_B2 = 4'd4,
        REQ_B3 = 4'd5,
        CAP_B3 = 4'd6,
        VALID  = 4'd7
    } ifu_state_t;

    // Anything not listed decodes as a single-byte instruction.
    function automatic logic [1:0] instr_length(input logic [7:0] op);
        case (op)
            OP_LDI_A, OP_ANI, OP_ORI, OP_XRI, OP_IN, OP_OUT: instr_length = 2'd2;
            OP_LDA, OP_STA, OP_JMP, OP_CALL:                 instr_length = 2'd3;
            default:                                         instr_length = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/ifu_prefetch_buf.sv
// One-byte opcode prefetch buffer with valid bit; flush has priority over write.
module ifu_prefetch_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
        end
        if (flush) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// SAP-2 instruction fetch: byte-serial fetch/assembly with valid/ready output,
// PC redirect and halt. Define IFU_PREFETCH_EN for the one-byte opcode prefetch.
module instr_fetch_unit
    import arch_defs_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic [15:0]           operand,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] pc_out,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    input  logic                  halt
);

    ifu_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_WIDTH-1:0] opcode_q, opcode_d;
    logic [15:0]           operand_q, operand_d;

    logic                  pf_issue, pf_hit, use_buf;
    logic [DATA_WIDTH-1:0] pf_data;
    logic [DATA_WIDTH-1:0] op_byte;

`ifdef IFU_PREFETCH_EN
    logic pf_pend_q, pf_pend_d;
    logic use_buf_q, use_buf_d;
    logic pf_valid, pf_flush;

    // A stalled VALID state spends its idle memory port on the next opcode.
    assign pf_issue = (state_q == VALID) && !instr_ready && !halt && !pc_load
                      && !pf_valid && !pf_pend_q;
    assign pf_hit   = pf_valid || pf_pend_q;
    assign pf_flush = pc_load || halt || ((state_q == CAP_OP) && use_buf_q);
    assign use_buf  = use_buf_q;

    always_comb begin
        pf_pend_d = pf_issue;
        use_buf_d = (state_q == VALID) && instr_ready && pf_hit && !halt && !pc_load;
    end

    ifu_prefetch_buf #(.DATA_WIDTH(DATA_WIDTH)) u_pf_buf (
        .clk     (clk),
        .reset   (reset),
        .flush   (pf_flush),
        .wr_en   (pf_pend_q),
        .wr_data (mem_rdata),
        .valid   (pf_valid),
        .data    (pf_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            pf_pend_q <= 1'b0;
            use_buf_q <= 1'b0;
        end else begin
            pf_pend_q <= pf_pend_d;
            use_buf_q <= use_buf_d;
        end
    end
`else
    assign pf_issue = 1'b0;
    assign pf_hit   = 1'b0;
    assign use_buf  = 1'b0;
    assign pf_data  = '0;
`endif

    assign op_byte = use_buf ? pf_data : mem_rdata;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        opcode_d   = opcode_q;
        operand_d  = operand_q;
        case (state_q)
            IDLE:   if (!halt) state_d = REQ_OP;
            REQ_OP: state_d = CAP_OP;
            CAP_OP: begin
                opcode_d   = op_byte;
                instr_pc_d = pc_q;
                pc_d       = pc_q + ADDR_WIDTH'(1);
                operand_d  = '0;
                state_d    = (instr_length(op_byte[7:0]) == 2'd1) ? VALID : REQ_B2;
            end
            REQ_B2: state_d = CAP_B2;
            CAP_B2: begin
                operand_d[7:0] = mem_rdata[7:0];
                pc_d           = pc_q + ADDR_WIDTH'(1);
                state_d        = (instr_length(opcode_q[7:0]) == 2'd2) ? VALID : REQ_B3;
            end
            REQ_B3: state_d = CAP_B3;
            CAP_B3: begin
                operand_d[15:8] = mem_rdata[7:0];
                pc_d            = pc_q + ADDR_WIDTH'(1);
                state_d         = VALID;
            end
            VALID: begin
                if (instr_ready) begin
                    if (halt)        state_d = IDLE;
                    else if (pf_hit) state_d = CAP_OP;
                    else             state_d = REQ_OP;
                end
            end
            default: state_d = REQ_OP;
        endcase
        // Redirect wins over everything; any partly assembled instruction is dropped.
        if (pc_load) begin
            pc_d    = pc_load_value;
            state_d = REQ_OP;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= REQ_OP;
            pc_q       <= RESET_VECTOR;
            instr_pc_q <= RESET_VECTOR;
            opcode_q   <= '0;
            operand_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            opcode_q   <= opcode_d;
            operand_q  <= operand_d;
        end
    end

    // Reset state is REQ_OP, so the strobe is gated to stay low while reset is held.
    assign mem_rd      = reset && ((state_q inside {REQ_OP, REQ_B2, REQ_B3}) || pf_issue);
    assign mem_addr    = pc_q;
    assign pc_out      = pc_q;
    assign instr_valid = (state_q == VALID);
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end stage of the SAP-2 CPU. Reads instruction bytes from program memory starting at the reset vector and assembles each multi-byte instruction (opcode plus up to two operand bytes). Presents the complete instruction to the execute/control stage through a valid/ready handshake. Supports PC redirect for jumps/calls and a halt input that stops fetching.

## Interface
- `ADDR_WIDTH`, 16: program address width.
- `DATA_WIDTH`, 8: memory byte width.
- `RESET_VECTOR`, 16'hF000: PC value after reset.
- `clk  in  1`: system clock; all state updates on the rising edge.
- `reset  in  1`: synchronous, active-low reset; resets state when sampled 0 on a `clk` edge.
- `mem_addr  out  ADDR_WIDTH`: read address.
- `mem_rd  out  1`: read strobe; data is returned on `mem_rdata` one cycle later.
- `mem_rdata  in  DATA_WIDTH`: read data.
- `instr_valid  out  1`: assembled instruction available.
- `instr_ready  in  1`: execute stage accepts the instruction.
- `opcode  out  DATA_WIDTH`: opcode byte.
- `operand  out  16`: byte2 in `[7:0]`, byte3 in `[15:8]`; unused bytes are 0.
- `instr_pc  out  ADDR_WIDTH`: address of the opcode byte.
- `pc_out  out  ADDR_WIDTH`: next fetch address.
- `pc_load  in  1`: redirect request.
- `pc_load_value  in  ADDR_WIDTH`: redirect target.
- `halt  in  1`: suppress new opcode fetches.

## Operation
- Instruction length (1–3) comes from `instr_length(opcode)`. Unknown opcodes have length 1.
- FSM states:
  - `IDLE`: halted; no reads.
  - `REQ_OP`: drive `mem_addr=pc`, `mem_rd=1`.
  - `CAP_OP`: latch opcode and `instr_pc`; pc+1; zero `operand`.
  - `REQ_B2` / `CAP_B2`: fetch byte2 into `operand[7:0]`.
  - `REQ_B3` / `CAP_B3`: fetch byte3 into `operand[15:8]`.
  - `VALID`: hold outputs.
- Transitions:
  - After `CAP_OP`, length 1 → `VALID`; otherwise → `REQ_B2`.
  - After `CAP_B2`, length 2 → `VALID`; length 3 → `REQ_B3`.
  - `CAP_B3` → `VALID`.
  - In `VALID`, `instr_ready=1` → `REQ_OP`, or `IDLE` if `halt=1`.
  - In `IDLE`, `halt=0` → `REQ_OP`.
- `halt` is sampled only when choosing to start a new opcode fetch. An instruction already in flight completes.
- pc wraps from 16'hFFFF to 16'h0000.
- `pc_load=1` overrides everything in any state:
  - next pc = `pc_load_value`, next state `REQ_OP`;
  - `instr_valid` drops next cycle;
  - any captured bytes and in-flight reads are discarded.
- If `instr_valid`, `instr_ready` and `pc_load` are all high in the same cycle, the handshake completes (instruction consumed) and the redirect is taken.
- Reset values:
  - state `REQ_OP`; pc = `RESET_VECTOR`;
  - `opcode`, `operand` = 0; `instr_pc` = `RESET_VECTOR`;
  - `instr_valid`, `mem_rd` = 0; `mem_addr` = `RESET_VECTOR`.
- Reset asserted mid-fetch aborts the fetch. No output retains pre-reset data.

## Timing
- Each byte takes 2 cycles: request, then capture.
- `instr_valid` rises 2 / 4 / 6 cycles after entering `REQ_OP` for 1 / 2 / 3-byte instructions.
- Handshake occurs on the edge where `instr_valid & instr_ready`. The next `REQ_OP` follows on the next cycle.
- While `instr_valid=1` and `instr_ready=0`, `opcode`, `operand` and `instr_pc` are stable.
- `mem_rd` is high only in REQ states, except for the prefetch read described under Configuration.

## Configuration
- `IFU_PREFETCH_EN`:
  - When defined, a stall in `VALID` issues a read of the next opcode at pc. The returned byte goes into a 1-entry prefetch buffer (pc+1).
  - On handshake with a full buffer, the FSM goes directly to `CAP_OP`-equivalent using the buffered byte. This saves 1 cycle.
  - `pc_load` or `halt` invalidates the buffer.
  - When undefined, there is no buffer and no read is issued in `VALID`.

## Structure
- `arch_defs_pkg` holds:
  - the `instr_length()` function;
  - `ifu_state_t` enum;
  - `RESET_VECTOR` default;
  - the opcode constants already present.
- Sub-module: `ifu_prefetch_buf`, a 1-byte buffer with valid bit and flush. It is instantiated only under `IFU_PREFETCH_EN`.

## Test plan
- ROM at F000 = `LDI_A`, AA, `ANI`, F0, `HLT`; `instr_ready` held 1:
  - opcode `LDI_A` with operand 0x00AA, `instr_valid` at cycle 4 after reset;
  - then `ANI` with operand 0x00F0 and `instr_pc` F002;
  - then `HLT` with `instr_pc` F004 and `pc_out` F005.
- 3-byte instruction with bytes 34, 12 → operand 0x1234; valid 6 cycles after `REQ_OP`.
- `instr_ready=0` for 5 cycles → all outputs stable and `pc_out` unchanged. With `IFU_PREFETCH_EN`, exactly one extra `mem_rd` occurs and the next instruction is valid 1 cycle earlier.
- `pc_load=1`, target 0x0010, during `CAP_B2` → next `mem_addr`=0x0010; old operand never presented.
- Assert `halt` during a 2-byte fetch → that instruction completes; then `mem_rd` stays 0. Deassert `halt` → fetch resumes at the correct pc.
- `reset=0` mid-fetch for one edge → `instr_valid`=0 and pc=F000. Fetch restarts and the first instruction matches the first scenario.
